// File: rtl/pe_stream_feeder_pkg.sv
// -----------------------------------------------------------------------------
// pe_stream_feeder_pkg
//   Shared definitions for the PE-array stream feeder: default array and
//   score geometry, feeder FSM state encoding, and the line-buffer entry
//   width helper.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package pe_stream_feeder_pkg;

  localparam int PE_ARRAY_SIZE     = 64;  // number of PEs in the array
  localparam int PE_ARRAY_SIZE_LOG = 6;   // log2 of the PE count
  localparam int V_E_F_BIT         = 16;  // score width
  localparam int MAX_T_SIZE_LOG    = 10;  // T address width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feed_state_e;

  // One line-buffer entry holds {t, v, f}: a 2-bit symbol and two scores.
  function automatic int line_entry_width(input int vef_w);
    return 2 + 2 * vef_w;
  endfunction

endpackage

// File: rtl/pe_stream_feeder_t_line_buffer.sv
// -----------------------------------------------------------------------------
// pe_stream_feeder_t_line_buffer
//   Simple dual-port RAM holding the last-PE {t,v,f} per T symbol.
//   One write port, one read port with a registered (1-cycle) read.
//   A read and write to the same index in one cycle returns the old data.
//   Ports:
//     clk, rst_n   clock, async active-low reset (read register only)
//     we/waddr/wdata  write port
//     raddr/rdata     read port, rdata valid the cycle after raddr
// -----------------------------------------------------------------------------
module pe_stream_feeder_t_line_buffer #(
  parameter int AW = 10,
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Write port: storage array has no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered read samples the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DW{1'b0}};
    end else begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// -----------------------------------------------------------------------------
// pe_stream_feeder
//   Data-processor side of the PE-array link. Loads S chunks of up to PE_N
//   symbols, streams all of T into PE 0 together with the previous pass's v/f
//   column, and captures the last-PE return stream into a line buffer that
//   feeds the next pass.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     i_start, i_t_size, i_alpha       job control
//     i_s_sym/_vld/_end, o_s_sym_rdy   S symbol source handshake
//     o_t_raddr, i_t_rdata             T SRAM (1-cycle read latency)
//     i_hold, o_lock                   stall request / array freeze
//     o_s, o_s_last, o_s_addr          S chunk load into the array
//     o_t, o_v, o_v_a, o_f, o_t_newline, o_enable_0   stream into PE 0
//     i_t, i_v, i_f, i_t_valid         last-PE return stream
//     o_busy, o_done                   job status
//   Optional build macro PE_FEED_STATS_EN adds o_pass_cnt (passes completed)
//   and o_stall_cnt (locked cycles while busy), both saturating, cleared on
//   job start.
// -----------------------------------------------------------------------------
module pe_stream_feeder
  import pe_stream_feeder_pkg::*;
#(
  parameter int PE_N  = PE_ARRAY_SIZE,
  parameter int VEF_W = V_E_F_BIT,
  parameter int T_LOG = MAX_T_SIZE_LOG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [T_LOG-1:0]          i_t_size,
  input  logic [VEF_W-1:0]          i_alpha,
  input  logic [1:0]                i_s_sym,
  input  logic                      i_s_sym_vld,
  input  logic                      i_s_sym_end,
  output logic                      o_s_sym_rdy,
  output logic [T_LOG-1:0]          o_t_raddr,
  input  logic [1:0]                i_t_rdata,
  input  logic                      i_hold,
  output logic                      o_lock,
  output logic [2*PE_N-1:0]         o_s,
  output logic                      o_s_last,
  output logic [$clog2(PE_N)-1:0]   o_s_addr,
  output logic [1:0]                o_t,
  output logic [VEF_W-1:0]          o_v,
  output logic [VEF_W-1:0]          o_v_a,
  output logic [VEF_W-1:0]          o_f,
  output logic                      o_t_newline,
  output logic                      o_enable_0,
  input  logic [1:0]                i_t,
  input  logic [VEF_W-1:0]          i_v,
  input  logic [VEF_W-1:0]          i_f,
  input  logic                      i_t_valid,
  output logic                      o_busy,
`ifdef PE_FEED_STATS_EN
  output logic [15:0]               o_pass_cnt,
  output logic [31:0]               o_stall_cnt,
`else
`endif
  output logic                      o_done
);

  localparam int PE_N_LOG = $clog2(PE_N);
  localparam int BUF_W    = line_entry_width(VEF_W);

  localparam logic [T_LOG-1:0]    T_ONE     = T_LOG'(1'b1);
  localparam logic [T_LOG-1:0]    T_ZERO    = {T_LOG{1'b0}};
  localparam logic [PE_N_LOG-1:0] SLOT_ONE  = PE_N_LOG'(1'b1);
  localparam logic [PE_N_LOG-1:0] SLOT_ZERO = {PE_N_LOG{1'b0}};
  localparam logic [PE_N_LOG-1:0] LAST_SLOT = PE_N_LOG'(PE_N - 1);

  feed_state_e          state_r, state_nxt_s;
  logic [T_LOG-1:0]     t_size_r;
  logic [T_LOG-1:0]     j_r, j_nxt_s;
  logic [T_LOG-1:0]     wcnt_r;
  logic [PE_N_LOG-1:0]  addr_r;
  logic [2*PE_N-1:0]    s_r;
  logic                 first_pass_r;
  logic                 s_ended_r;
  logic                 out_of_reset_r;

  logic                 lock_s;
  logic                 start_s;
  logic                 accept_s;
  logic                 load_exit_s;
  logic                 stream_exit_s;
  logic                 drain_exit_s;
  logic                 stream_s;
  logic                 busy_s;
  logic                 capture_s;
  logic [T_LOG-1:0]     addr_ext_s;
  logic [BUF_W-1:0]     buf_rdata_s;
  logic [VEF_W-1:0]     v_s;
  logic [VEF_W-1:0]     f_s;
  logic                 buf_t_unused_s;

  // Gap-open adjusted score, floored at zero.
  function automatic logic [VEF_W-1:0] gap_sub(input logic [VEF_W-1:0] v,
                                               input logic [VEF_W-1:0] a);
    if (v > a) begin
      return v - a;
    end else begin
      return {VEF_W{1'b0}};
    end
  endfunction

  assign stream_s   = (state_r == ST_STREAM);
  assign busy_s     = (state_r != ST_IDLE);
  assign addr_ext_s = T_LOG'(addr_r);

  // While rst_n is low (and the first cycle after) the array stays frozen.
  assign lock_s = ~out_of_reset_r | i_hold | ((state_r == ST_LOAD) & ~i_s_sym_vld);

  assign start_s       = (state_r == ST_IDLE) & i_start;
  assign accept_s      = (state_r == ST_LOAD) & ~lock_s;
  assign load_exit_s   = accept_s & ((addr_r == LAST_SLOT) | i_s_sym_end |
                                     (addr_ext_s == (t_size_r - T_ONE)));
  assign stream_exit_s = stream_s & ~lock_s & (j_r == (t_size_r - T_ONE));
  assign drain_exit_s  = (state_r == ST_DRAIN) & ~lock_s & (wcnt_r == t_size_r);
  assign capture_s     = i_t_valid & busy_s;

  // Next-state and stream index; the index also drives the read addresses one cycle ahead.
  always_comb begin
    state_nxt_s = state_r;
    j_nxt_s     = j_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_exit_s) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_STREAM: begin
        if (stream_exit_s) begin
          state_nxt_s = ST_DRAIN;
          j_nxt_s     = T_ZERO;
        end else if (~lock_s) begin
          j_nxt_s     = j_r + T_ONE;
        end else begin
          j_nxt_s     = j_r;
        end
      end
      ST_DRAIN: begin
        if (drain_exit_s) begin
          if (s_ended_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        j_nxt_s     = T_ZERO;
      end
    endcase
  end

  // FSM state and stream index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      j_r     <= T_ZERO;
    end else begin
      state_r <= state_nxt_s;
      j_r     <= j_nxt_s;
    end
  end

  // Marks the first clock after reset release so the lock can drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset_r <= 1'b0;
    end else begin
      out_of_reset_r <= 1'b1;
    end
  end

  // Job context, chunk load and capture pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_size_r     <= T_ZERO;
      addr_r       <= SLOT_ZERO;
      s_r          <= {(2*PE_N){1'b0}};
      first_pass_r <= 1'b1;
      s_ended_r    <= 1'b0;
      wcnt_r       <= T_ZERO;
    end else if (start_s) begin
      t_size_r     <= i_t_size;
      addr_r       <= SLOT_ZERO;
      s_r          <= {(2*PE_N){1'b0}};
      first_pass_r <= 1'b1;
      s_ended_r    <= 1'b0;
      wcnt_r       <= T_ZERO;
    end else begin
      if (accept_s) begin
        s_r[{addr_r, 1'b0} +: 2] <= i_s_sym;
        addr_r <= load_exit_s ? SLOT_ZERO : (addr_r + SLOT_ONE);
        if (i_s_sym_end) begin
          s_ended_r <= 1'b1;
        end
      end
      // A pass is complete once every streamed symbol has come back.
      if (drain_exit_s) begin
        wcnt_r       <= T_ZERO;
        first_pass_r <= 1'b0;
        if (!s_ended_r) begin
          s_r <= {(2*PE_N){1'b0}};
        end
      end else if (capture_s) begin
        wcnt_r <= wcnt_r + T_ONE;
      end
    end
  end

  pe_stream_feeder_t_line_buffer #(
    .AW (T_LOG),
    .DW (BUF_W)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (capture_s),
    .waddr (wcnt_r),
    .wdata ({i_t, i_v, i_f}),
    .raddr (j_nxt_s),
    .rdata (buf_rdata_s)
  );

  // The stored t is kept for completeness; only v/f feed the next pass.
  assign buf_t_unused_s = ^buf_rdata_s[BUF_W-1 -: 2];

  // Pass 0 has no previous column, so v/f start from zero.
  assign v_s = (stream_s & ~first_pass_r) ? buf_rdata_s[2*VEF_W-1:VEF_W] : {VEF_W{1'b0}};
  assign f_s = (stream_s & ~first_pass_r) ? buf_rdata_s[VEF_W-1:0]       : {VEF_W{1'b0}};

  assign o_t_raddr   = j_nxt_s;
  assign o_t         = stream_s ? i_t_rdata : 2'b00;
  assign o_v         = v_s;
  assign o_f         = f_s;
  assign o_v_a       = gap_sub(v_s, i_alpha);
  assign o_t_newline = stream_s & (j_r == T_ZERO);
  assign o_enable_0  = stream_s;
  assign o_lock      = lock_s;
  assign o_s_sym_rdy = (state_r == ST_LOAD) & out_of_reset_r & ~i_hold;
  assign o_s         = s_r;
  assign o_s_addr    = addr_r;
  assign o_s_last    = (state_r == ST_LOAD) & i_s_sym_vld & i_s_sym_end;
  assign o_busy      = busy_s;
  assign o_done      = (state_r == ST_DONE);

`ifdef PE_FEED_STATS_EN
  logic [15:0] pass_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating job statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_r  <= 16'h0000;
      stall_cnt_r <= 32'h0000_0000;
    end else if (start_s) begin
      pass_cnt_r  <= 16'h0000;
      stall_cnt_r <= 32'h0000_0000;
    end else begin
      if (drain_exit_s && (pass_cnt_r != 16'hFFFF)) begin
        pass_cnt_r <= pass_cnt_r + 16'h0001;
      end
      if (lock_s && busy_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end
    end
  end

  assign o_pass_cnt  = pass_cnt_r;
  assign o_stall_cnt = stall_cnt_r;
`else
`endif

endmodule

// File: tb/tb_pe_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_pe_stream_feeder
//   Self-checking bench for pe_stream_feeder with PE_N=4. A cycle-level phase
//   model predicts handshake/status outputs; returned v/f values are pushed to
//   a scoreboard queue when driven and popped when the next pass streams them.
// -----------------------------------------------------------------------------
module tb_pe_stream_feeder;

  localparam int PE_N  = 4;
  localparam int VEF_W = 16;
  localparam int T_LOG = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_STREAM = 2, P_DRAIN = 3, P_DONE = 4;
  localparam logic [VEF_W-1:0] ALPHA = 16'd7;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   i_start;
  logic [T_LOG-1:0]       i_t_size;
  logic [VEF_W-1:0]       i_alpha;
  logic [1:0]             i_s_sym;
  logic                   i_s_sym_vld;
  logic                   i_s_sym_end;
  logic                   o_s_sym_rdy;
  logic [T_LOG-1:0]       o_t_raddr;
  logic [1:0]             t_rdata;
  logic                   i_hold;
  logic                   o_lock;
  logic [2*PE_N-1:0]      o_s;
  logic                   o_s_last;
  logic [1:0]             o_s_addr;
  logic [1:0]             o_t;
  logic [VEF_W-1:0]       o_v, o_v_a, o_f;
  logic                   o_t_newline, o_enable_0;
  logic [1:0]             i_t;
  logic [VEF_W-1:0]       i_v, i_f;
  logic                   i_t_valid;
  logic                   o_busy, o_done;
`ifdef PE_FEED_STATS_EN
  logic [15:0]            o_pass_cnt;
  logic [31:0]            o_stall_cnt;
`endif

  typedef struct {
    int               due;
    logic [1:0]       t;
    logic [VEF_W-1:0] v;
    logic [VEF_W-1:0] f;
  } ret_t;

  ret_t                 ret_q[$];
  logic [2*VEF_W-1:0]   exp_vf_q[$];
  logic [1:0]           s_seq[16];
  logic [1:0]           t_mem[16];
  int                   s_len, t_size, hold_at, abort_at;
  bit                   gap_en;
  int                   n_tests = 0;
  int                   n_fail  = 0;

  always #5 clk = ~clk;

  // T SRAM model: one-cycle read latency.
  always @(posedge clk) t_rdata <= t_mem[o_t_raddr];

  pe_stream_feeder #(.PE_N(PE_N), .VEF_W(VEF_W), .T_LOG(T_LOG)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_t_size(i_t_size), .i_alpha(i_alpha),
    .i_s_sym(i_s_sym), .i_s_sym_vld(i_s_sym_vld), .i_s_sym_end(i_s_sym_end),
    .o_s_sym_rdy(o_s_sym_rdy), .o_t_raddr(o_t_raddr), .i_t_rdata(t_rdata),
    .i_hold(i_hold), .o_lock(o_lock), .o_s(o_s), .o_s_last(o_s_last), .o_s_addr(o_s_addr),
    .o_t(o_t), .o_v(o_v), .o_v_a(o_v_a), .o_f(o_f), .o_t_newline(o_t_newline),
    .o_enable_0(o_enable_0), .i_t(i_t), .i_v(i_v), .i_f(i_f), .i_t_valid(i_t_valid),
    .o_busy(o_busy),
`ifdef PE_FEED_STATS_EN
    .o_pass_cnt(o_pass_cnt), .o_stall_cnt(o_stall_cnt),
`endif
    .o_done(o_done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_s_sym_vld = 1'b0; i_s_sym_end = 1'b0; i_s_sym = 2'd0;
    i_hold = 1'b0; i_t_valid = 1'b0; i_t = 2'd0; i_v = '0; i_f = '0;
  endtask

  task automatic load_job(input int sl, input logic [31:0] sv, input int tl,
                          input logic [31:0] tv, input int h, input int ab, input bit g);
    s_len = sl; t_size = tl; hold_at = h; abort_at = ab; gap_en = g;
    for (int k = 0; k < 16; k++) begin
      s_seq[k] = sv[2*k +: 2];
      t_mem[k] = tv[2*k +: 2];
    end
  endtask

  task automatic run_job();
    int phase = P_IDLE;
    int s_idx = 0, slot = 0, j = 0, pass = 0, cap_cnt = 0, hold_left = 3, cyc = 0;
    bit started = 1'b0, finished = 1'b0, hold = 1'b0, vld = 1'b0, ret_now = 1'b0;
    logic [2*PE_N-1:0] exp_s = '0;
    logic [VEF_W-1:0]  ev, ef, eva;
    logic [2*VEF_W-1:0] vf;
    ret_t r;
    ret_q.delete();
    exp_vf_q.delete();
    while (!finished) begin
      @(negedge clk);
      cyc++;
      if (cyc > 600) begin
        check_val("job_timeout", 64'd1, 64'd0);
        break;
      end
      if (phase == P_STREAM && j == abort_at) begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_val("abort_lock", o_lock, 1'b1);
        check_val("abort_busy", o_busy, 1'b0);
        check_val("abort_enable", o_enable_0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      // drive this cycle's inputs
      i_start  = !started || (phase == P_STREAM && j == 1);
      i_t_size = started ? T_LOG'(t_size + 3) : T_LOG'(t_size);
      vld = (s_idx < s_len) && !(gap_en && (cyc % 3 == 0));
      i_s_sym_vld = vld;
      i_s_sym     = (s_idx < s_len) ? s_seq[s_idx] : 2'd0;
      i_s_sym_end = (s_idx == s_len - 1);
      hold = (phase == P_STREAM && j == hold_at && hold_left > 0);
      if (hold) hold_left--;
      i_hold = hold;
      ret_now = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        i_t_valid = 1'b1; i_t = r.t; i_v = r.v; i_f = r.f;
        exp_vf_q.push_back({r.v, r.f});
        ret_now = 1'b1;
      end else begin
        i_t_valid = 1'b0;
      end
      #1;
      check_val("busy",   o_busy,      phase != P_IDLE);
      check_val("lock",   o_lock,      hold || (phase == P_LOAD && !vld));
      check_val("enable", o_enable_0,  phase == P_STREAM);
      check_val("done",   o_done,      phase == P_DONE);
      check_val("rdy",    o_s_sym_rdy, phase == P_LOAD && !hold);
      case (phase)
        P_IDLE: begin
          started = 1'b1;
          phase = P_LOAD;
        end
        P_LOAD: begin
          if (vld && !hold) begin
            check_val("s_addr", o_s_addr, slot);
            check_val("s_last", o_s_last, s_idx == s_len - 1);
            exp_s[2*slot +: 2] = s_seq[s_idx];
            if (slot == PE_N - 1 || s_idx == s_len - 1 || slot == t_size - 1) begin
              phase = P_STREAM; j = 0; slot = 0;
            end else begin
              slot++;
            end
            s_idx++;
          end
        end
        P_STREAM: begin
          check_val("t", o_t, t_mem[j]);
          check_val("newline", o_t_newline, j == 0);
          if (!hold) begin
            if (j == 0) check_val("s_vec", o_s, exp_s);
            if (pass == 0) begin
              ev = '0; ef = '0;
            end else if (exp_vf_q.size() == 0) begin
              check_val("sb_empty", 64'd1, 64'd0);
              ev = '0; ef = '0;
            end else begin
              vf = exp_vf_q.pop_front();
              ev = vf[2*VEF_W-1:VEF_W]; ef = vf[VEF_W-1:0];
            end
            eva = (ev > ALPHA) ? ev - ALPHA : '0;
            check_val("v", o_v, ev);
            check_val("f", o_f, ef);
            check_val("v_a", o_v_a, eva);
            r.due = cyc + PE_N + 1;
            r.t = t_mem[j];
            r.v = VEF_W'(5 + 15*j + 100*pass);
            r.f = VEF_W'(1 + 2*j + 13*pass);
            ret_q.push_back(r);
            j++;
            if (j == t_size) begin
              phase = P_DRAIN; j = 0;
            end
          end
        end
        P_DRAIN: begin
          if (cap_cnt == t_size && !hold) begin
            pass++; cap_cnt = 0;
            if (s_idx == s_len) begin
              phase = P_DONE;
            end else begin
              phase = P_LOAD; exp_s = '0;
            end
          end
        end
        P_DONE: begin
          phase = P_IDLE; finished = 1'b1;
        end
        default: phase = P_IDLE;
      endcase
      if (ret_now) cap_cnt++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check_val("post_busy", o_busy, 1'b0);
    check_val("post_done", o_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    i_alpha = ALPHA;
    i_t_size = '0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_lock", o_lock, 1'b1);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_done", o_done, 1'b0);
    check_val("rst_s", o_s, 8'h00);
    check_val("rst_enable", o_enable_0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("idle_lock", o_lock, 1'b0);

    // S=ACG, T=ACGT: one pass, three slots
    load_job(3, 32'h24, 4, 32'hE4, -1, -1, 1'b0);
    run_job();
    // 8 symbols, T=5: two full chunks, second pass reads the captures
    load_job(8, 32'hB1E4, 5, 32'h036C, -1, -1, 1'b0);
    run_job();
    // hold for three cycles mid-stream
    load_job(4, 32'h1B, 8, 32'h9C2D, 2, -1, 1'b0);
    run_job();
    // valid gaps during load
    load_job(4, 32'hD2, 6, 32'h0B47, -1, -1, 1'b1);
    run_job();
    // t_size=1: every pass is a single-cycle stream
    load_job(3, 32'h39, 1, 32'h2, -1, -1, 1'b0);
    run_job();
    // reset mid-stream, then a normal job
    load_job(4, 32'h4E, 6, 32'h0E71, -1, 2, 1'b0);
    run_job();
    load_job(5, 32'h2C9, 3, 32'h1B, -1, -1, 1'b0);
    run_job();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
